memoria_principal_responder: RTL and testbench

- Memory-side responder that serves the cache's miss traffic: dirty-block write-backs and block fills.
- 32 x 8-bit backing store addressed by the 5-bit tag, with programmable access latency.
- Single outstanding transaction; a combined write-back + fill request is sequenced write first, then read.
- `leitura_pronta` feeds the cache's `solicitacao_anterior_de_escrita_na_cache` so the cache captures the fill.

---
 rtl/memoria_principal_responder.sv | 123 ++++++++++++
 tb/tb_memoria_principal_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_principal_responder.sv
// Memory-side responder for cache misses: 32 x 8-bit backing store serving
// dirty-block write-backs and block fills with a programmable access latency.
module memoria_principal_responder #(
  parameter int unsigned LATENCIA     = 2,
  parameter int unsigned LARGURA      = 8,
  parameter int unsigned PROFUNDIDADE = 32
) (
  input  logic               clock1,
  input  logic               Reset,
  input  logic               solicitacao_de_leitura_na_memoria,
  input  logic               solicitacao_de_escrita_na_memoria,
  input  logic [4:0]         tag_de_leitura,
  input  logic [4:0]         tag_de_escrita,
  input  logic [LARGURA-1:0] bloco_a_ser_escrito_na_memoria,
  output logic [LARGURA-1:0] bloco_lido_da_memoria,
  output logic               leitura_pronta,
  output logic               escrita_concluida,
  output logic               ocupado,
  output logic               erro_solicitacao
);

  localparam int unsigned AW    = $clog2(PROFUNDIDADE);
  localparam logic [3:0]  CARGA = 4'(LATENCIA - 1);

  if (LATENCIA == 0 || LATENCIA > 15) begin : g_latencia_invalida
    $error("LATENCIA must be in 1..15");
  end

  typedef enum logic [1:0] {OCIOSO, ESCRITA, LEITURA} estado_t;

  estado_t            r_estado, w_estado_prox;
  logic [3:0]         r_cont, w_cont_prox;
  logic               r_pend, w_pend_prox;
  logic [4:0]         r_tag_lei, r_tag_esc;
  logic [LARGURA-1:0] r_dado_esc;
  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic               w_req, w_captura, w_grava, w_le;

  assign w_req   = solicitacao_de_leitura_na_memoria | solicitacao_de_escrita_na_memoria;
  assign ocupado = (r_estado != OCIOSO);

  always_comb begin
    w_estado_prox = r_estado;
    w_cont_prox   = r_cont;
    w_pend_prox   = r_pend;
    w_captura     = 1'b0;
    w_grava       = 1'b0;
    w_le          = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_req) begin
          w_captura     = 1'b1;
          w_cont_prox   = CARGA;
          w_pend_prox   = solicitacao_de_leitura_na_memoria;
          w_estado_prox = solicitacao_de_escrita_na_memoria ? ESCRITA : LEITURA;
        end
      end
      ESCRITA: begin
        if (r_cont != 4'd0) begin
          w_cont_prox = r_cont - 4'd1;
        end else begin
          w_grava = 1'b1;
          // Combined request: the read phase starts right after the commit.
          if (r_pend) begin
            w_cont_prox   = CARGA;
            w_estado_prox = LEITURA;
          end else begin
            w_estado_prox = OCIOSO;
          end
        end
      end
      LEITURA: begin
        if (r_cont != 4'd0) begin
          w_cont_prox = r_cont - 4'd1;
        end else begin
          w_le          = 1'b1;
          w_pend_prox   = 1'b0;
          w_estado_prox = OCIOSO;
        end
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock1) begin
    if (!Reset) begin
      r_estado <= OCIOSO;
      r_cont   <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_cont   <= w_cont_prox;
      r_pend   <= w_pend_prox;
    end
  end

  always_ff @(posedge clock1) begin
    if (!Reset) begin
      bloco_lido_da_memoria <= '0;
      leitura_pronta        <= 1'b0;
      escrita_concluida     <= 1'b0;
      erro_solicitacao      <= 1'b0;
      r_tag_lei             <= '0;
      r_tag_esc             <= '0;
      r_dado_esc            <= '0;
      for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
        r_mem[AW'(i)] <= LARGURA'(i);
      end
    end else begin
      leitura_pronta    <= w_le;
      escrita_concluida <= w_grava;
      erro_solicitacao  <= w_req && (r_estado != OCIOSO);
      if (w_captura) begin
        r_tag_lei  <= tag_de_leitura;
        r_tag_esc  <= tag_de_escrita;
        r_dado_esc <= bloco_a_ser_escrito_na_memoria;
      end
      if (w_grava) r_mem[r_tag_esc] <= r_dado_esc;
      if (w_le) bloco_lido_da_memoria <= r_mem[r_tag_lei];
    end
  end

endmodule

// File: tb/tb_memoria_principal_responder.sv
// Bench for memoria_principal_responder: directed scenarios plus random traffic,
// checked against a transaction-level timing/memory model.
module tb_memoria_principal_responder;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rd, wr;
  logic [4:0] trd, twr;
  logic [7:0] dwr;
  logic [7:0] bloco;
  logic       lp, wc, busy, err;

  logic       s1_rd;
  logic [4:0] s1_tag;
  logic [4:0] s1_tag_esc = '0;
  logic [7:0] s1_dado    = '0;
  logic [7:0] bloco1;
  logic       lp1, wc1, busy1, err1;

  memoria_principal_responder #(.LATENCIA(LAT)) dut (
    .clock1(clk), .Reset(rst_n),
    .solicitacao_de_leitura_na_memoria(rd),
    .solicitacao_de_escrita_na_memoria(wr),
    .tag_de_leitura(trd), .tag_de_escrita(twr),
    .bloco_a_ser_escrito_na_memoria(dwr),
    .bloco_lido_da_memoria(bloco), .leitura_pronta(lp),
    .escrita_concluida(wc), .ocupado(busy), .erro_solicitacao(err)
  );

  memoria_principal_responder #(.LATENCIA(1)) dut1 (
    .clock1(clk), .Reset(rst_n),
    .solicitacao_de_leitura_na_memoria(s1_rd),
    .solicitacao_de_escrita_na_memoria(1'b0),
    .tag_de_leitura(s1_tag), .tag_de_escrita(s1_tag_esc),
    .bloco_a_ser_escrito_na_memoria(s1_dado),
    .bloco_lido_da_memoria(bloco1), .leitura_pronta(lp1),
    .escrita_concluida(wc1), .ocupado(busy1), .erro_solicitacao(err1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image plus the edge numbers at which events occur.
  int         cyc = 0;
  int         busy_end = 0;
  int         wc_at = -1;
  int         lp_at = -1;
  logic [7:0] m_mem [32];
  logic [7:0] m_data;
  logic [4:0] m_wt, m_rt;
  logic [7:0] m_wd;
  logic       exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'(i);
    busy_end = cyc;
    wc_at    = -1;
    lp_at    = -1;
    m_data   = '0;
  endtask

  task automatic check_outputs();
    chk("ocupado",    32'(busy), 32'(cyc < busy_end));
    chk("esc_conc",   32'(wc),   32'(cyc == wc_at));
    chk("lei_pronta", 32'(lp),   32'(cyc == lp_at));
    chk("erro",       32'(err),  32'(exp_err));
    chk("bloco",      32'(bloco), 32'(m_data));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      model_reset();
      #1;
      chk("rst_ocupado", 32'(busy), 32'd0);
      chk("rst_esc",     32'(wc),   32'd0);
      chk("rst_lei",     32'(lp),   32'd0);
      chk("rst_erro",    32'(err),  32'd0);
      chk("rst_bloco",   32'(bloco), 32'd0);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] tr,
                      input logic [4:0] tw, input logic [7:0] d);
    logic bsy_prev;
    rd = r; wr = w; trd = tr; twr = tw; dwr = d; rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    bsy_prev = (cyc - 1 < busy_end);
    if (cyc == wc_at) m_mem[m_wt] = m_wd;
    if (cyc == lp_at) m_data = m_mem[m_rt];
    exp_err = (r || w) && bsy_prev;
    if ((r || w) && !bsy_prev) begin
      if (w) begin
        wc_at = cyc + LAT;
        m_wt  = tw;
        m_wd  = d;
      end
      if (r) begin
        lp_at = cyc + (w ? 2 * LAT : LAT);
        m_rt  = tr;
      end
      busy_end = cyc + ((r && w) ? 2 * LAT : LAT);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 8'd0);
  endtask

  initial begin
    rd = 0; wr = 0; trd = '0; twr = '0; dwr = '0; s1_rd = 0; s1_tag = '0;
    exp_err = 0;
    do_reset(2);

    step(1, 0, 5'd7, 5'd0, 8'h00);
    chk("rd7_busy", 32'(busy), 32'd1);
    idle();
    idle();
    chk("rd7_pronta", 32'(lp), 32'd1);
    chk("rd7_dado", 32'(bloco), 32'h07);
    chk("rd7_livre", 32'(busy), 32'd0);
    idle();

    step(0, 1, 5'd0, 5'd3, 8'hA5);
    idle();
    idle();
    chk("wr3_conc", 32'(wc), 32'd1);
    idle();
    step(1, 0, 5'd3, 5'd0, 8'h00);
    idle();
    idle();
    chk("rd3_dado", 32'(bloco), 32'hA5);
    idle();
    step(1, 0, 5'd2, 5'd0, 8'h00);
    idle();
    idle();
    chk("rd2_dado", 32'(bloco), 32'h02);
    idle();

    step(1, 1, 5'd4, 5'd4, 8'h3C);
    idle();
    idle();
    chk("comb_conc", 32'(wc), 32'd1);
    chk("comb_busy", 32'(busy), 32'd1);
    idle();
    idle();
    chk("comb_pronta", 32'(lp), 32'd1);
    chk("comb_dado", 32'(bloco), 32'h3C);
    chk("comb_livre", 32'(busy), 32'd0);
    idle();

    step(0, 1, 5'd0, 5'd1, 8'h55);
    step(1, 0, 5'd9, 5'd0, 8'h00);
    chk("ocup_erro", 32'(err), 32'd1);
    idle();
    chk("ocup_sem_lei", 32'(lp), 32'd0);
    chk("ocup_bloco", 32'(bloco), 32'h3C);
    idle();
    step(1, 0, 5'd9, 5'd0, 8'h00);
    idle();
    idle();
    chk("rd9_dado", 32'(bloco), 32'h09);
    idle();

    step(0, 1, 5'd0, 5'd5, 8'hFF);
    do_reset(1);
    idle();
    idle();
    idle();
    step(1, 0, 5'd5, 5'd0, 8'h00);
    idle();
    idle();
    chk("rd5_dado", 32'(bloco), 32'h05);
    idle();

    s1_rd = 1; s1_tag = 5'd10;
    idle();
    chk("l1_busy", 32'(busy1), 32'd1);
    s1_rd = 0;
    idle();
    chk("l1_pronta10", 32'(lp1), 32'd1);
    chk("l1_dado10", 32'(bloco1), 32'h0A);
    chk("l1_erro_a", 32'(err1), 32'd0);
    s1_rd = 1; s1_tag = 5'd11;
    idle();
    chk("l1_erro_b", 32'(err1), 32'd0);
    chk("l1_busy11", 32'(busy1), 32'd1);
    s1_rd = 0;
    idle();
    chk("l1_pronta11", 32'(lp1), 32'd1);
    chk("l1_dado11", 32'(bloco1), 32'h0B);
    chk("l1_erro_c", 32'(err1), 32'd0);

    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 99) == 0) begin
        rd = 1'($urandom); wr = 1'($urandom);
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             5'($urandom), 5'($urandom), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
